// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises sclk/copi/ncs into clk and emits one word per legal frame.
// Optional illegal-frame counter is built only when SPI_ERR_COUNT_EN is defined.
module spi_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  copi,
    input  logic                  ncs,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_OVER = CW'(FRAME_BITS + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state, state_next;
    logic [SYNC_STAGES-1:0]  sclk_sync, copi_sync, ncs_sync;
    logic                    sclk_d, copi_d, ncs_d;
    logic                    sclk_rise, ncs_fall, ncs_rise;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next, data_next;
    logic [CW-1:0]           count, count_next;
    logic                    valid_next, err_next;

    // Synchronisers and edge-detect flops reset to the bus idle levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            copi_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            copi_d    <= copi_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    assign ncs_fall  = ~ncs_sync[SYNC_STAGES-1] & ncs_d;
    assign ncs_rise  = ncs_sync[SYNC_STAGES-1] & ~ncs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            count       <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_next;
            shift_reg   <= shift_next;
            count       <= count_next;
            frame_data  <= data_next;
            frame_valid <= valid_next;
            frame_err   <= err_next;
        end
    end

    always_comb begin
        // NOTE: every output defaults first so no path leaves one unassigned (no latches).
        state_next = state;
        shift_next = shift_reg;
        count_next = count;
        data_next  = frame_data;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) begin
                    state_next = ACTIVE;
                    shift_next = '0;
                    count_next = '0;
                end
            end
            ACTIVE: begin
                // A clock edge coinciding with the end of frame is dropped.
                if (ncs_rise) begin
                    state_next = IDLE;
                    if (count == CNT_FULL) begin
                        valid_next = 1'b1;
                        data_next  = shift_reg;
                    end else if (count != '0) begin
                        err_next = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_next = {shift_reg[FRAME_BITS-2:0], copi_d};
                    if (count != CNT_OVER)
                        count_next = count + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == ACTIVE);

`ifdef SPI_ERR_COUNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (err_next && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end

    assign err_count = err_cnt;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: table of whole frames plus hand-written corner sequences.
// Expected err_count follows SPI_ERR_COUNT_EN.
module tb_spi_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, copi, ncs;
    logic [15:0] frame_data;
    logic        frame_valid, frame_err, busy;
    logic [7:0]  err_count;

    int n_vec  = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;
    int busy_low = 0;
    int exp_ec   = 0;
    logic [15:0] exp_data = 16'h0000;

    spi_frame_rx dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        if (frame_valid && frame_err) n_both++;
    end

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          exp_valid;
        int          exp_err;
        logic [15:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bump_ec(input int ec);
`ifdef SPI_ERR_COUNT_EN
        return (ec < 255) ? ec + 1 : 255;
`else
        return 0;
`endif
    endfunction

    task automatic begin_frame();
        @(negedge clk);
        ncs  = 1'b0;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // f_clk/8: four clk low, four clk high, copi changes with the falling edge.
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (!busy) busy_low++;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input logic [31:0] bits, input int n);
        begin_frame();
        send_bits(bits, n);
        end_frame();
    endtask

    vec_t vecs[8];

    initial begin
        int v0, e0, b0;

        vecs[0] = '{32'h0000_0ABC, 12, 0, 1, 16'h807F};
        vecs[1] = '{32'h0000_A5C3, 16, 1, 0, 16'hA5C3};
        vecs[2] = '{32'h000F_FFFF, 20, 0, 1, 16'hA5C3};
        vecs[3] = '{32'h0000_0001, 16, 1, 0, 16'h0001};
        vecs[4] = '{32'h0001_FFFF, 17, 0, 1, 16'h0001};
        vecs[5] = '{32'h0000_1234, 15, 0, 1, 16'h0001};
        vecs[6] = '{32'h0000_FFFF, 16, 1, 0, 16'hFFFF};
        vecs[7] = '{32'h0000_0001, 1,  0, 1, 16'hFFFF};

        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        repeat (3) @(negedge clk);
        check("reset frame_data", frame_data, 16'h0);
        check("reset frame_valid", frame_valid, 0);
        check("reset frame_err", frame_err, 0);
        check("reset busy", busy, 0);
        check("reset err_count", err_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Legal frame with pulse-position check: valid only after the 3rd edge sampling ncs high.
        v0 = n_valid; e0 = n_err; b0 = busy_low;
        begin_frame();
        send_bits(32'h807F, 16);
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            check($sformatf("legal valid after edge %0d", e), frame_valid, (e == 3));
        end
        repeat (6) @(negedge clk);
        exp_data = 16'h807F;
        check("legal data", frame_data, exp_data);
        check("legal valid count", n_valid - v0, 1);
        check("legal err count", n_err - e0, 0);
        check("legal busy throughout", busy_low - b0, 0);
        check("legal idle after", busy, 0);

        for (int i = 0; i < 8; i++) begin
            v0 = n_valid; e0 = n_err; b0 = busy_low;
            run_frame(vecs[i].bits, vecs[i].nbits);
            if (vecs[i].exp_err != 0) exp_ec = bump_ec(exp_ec);
            check($sformatf("vec%0d valid", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d err", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("vec%0d data", i), frame_data, vecs[i].exp_data);
            check($sformatf("vec%0d err_count", i), err_count, exp_ec);
            check($sformatf("vec%0d busy", i), busy_low - b0, 0);
        end
        exp_data = 16'hFFFF;

        // Stray SCLK with ncs high.
        v0 = n_valid; e0 = n_err; b0 = 0;
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            if (busy) b0++;
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            if (busy) b0++;
        end
        check("stray busy", b0, 0);
        check("stray pulses", (n_valid - v0) + (n_err - e0), 0);
        check("stray data", frame_data, exp_data);

        // Chip-select glitch, no SCLK.
        v0 = n_valid; e0 = n_err;
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch pulses", (n_valid - v0) + (n_err - e0), 0);
        check("glitch busy", busy, 0);

        // 17th SCLK rise lands in the same cycle as ncs rise.
        v0 = n_valid; e0 = n_err;
        begin_frame();
        send_bits(32'h3C5A, 16);
        copi = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        ncs  = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        exp_data = 16'h3C5A;
        check("simul valid", n_valid - v0, 1);
        check("simul err", n_err - e0, 0);
        check("simul data", frame_data, exp_data);

        // Saturation of the error counter.
        e0 = n_err;
        for (int i = 0; i < 300; i++) begin
            run_frame(32'h1, 1);
            exp_ec = bump_ec(exp_ec);
        end
        check("sat err pulses", n_err - e0, 300);
        check("sat err_count", err_count, exp_ec);
        check("sat data held", frame_data, exp_data);

        // Reset mid-frame with ncs held low.
        begin_frame();
        send_bits(32'hFF, 8);
        rst = 1'b1;
        #1;
        check("midrst frame_data", frame_data, 16'h0);
        check("midrst frame_valid", frame_valid, 0);
        check("midrst frame_err", frame_err, 0);
        check("midrst busy", busy, 0);
        check("midrst err_count", err_count, 0);
        exp_ec = 0;
        exp_data = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst reenter busy", busy, 1);
        v0 = n_valid; e0 = n_err;
        send_bits(32'hA5, 8);
        end_frame();
        exp_ec = bump_ec(exp_ec);
        check("midrst valid", n_valid - v0, 0);
        check("midrst err", n_err - e0, 1);
        check("midrst data", frame_data, exp_data);
        check("midrst err_count after", err_count, exp_ec);

        check("valid and err never together", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
